// File: rtl/sdram_test_gen_pkg.sv
// Shared definitions for the SDRAM pattern tester.
//   state_e     : FSM state enumeration (also driven out as a debug port)
//   MODE_*      : encodings of the mode_i pattern selector
//   lfsr_taps() : maximal-length Galois tap masks for widths 8..32. Bit k
//                 of the mask corresponds to polynomial term x^(k+1). Use it
//                 with a right-shifting register: when the bit shifted out of
//                 bit 0 is 1, XOR the mask into the shifted value.
package sdram_test_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_READ     = 3'd2,
    ST_CHECK    = 3'd3,
    ST_PASS_END = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [1:0] MODE_ADDR = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;
  localparam logic [1:0] MODE_INV  = 2'd3;

  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_00B8;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/sdram_test_gen_pattern_gen.sv
// sdram_pattern_gen: purely combinational pattern source, shared by the
// write path and the read-back check so both always agree on a word.
//   addr_i      : word address being written or checked
//   mode_i      : pattern selector (see MODE_* in the package)
//   lfsr_i      : current LFSR state
//   exp_o       : data word for this address/state
//   lfsr_next_o : LFSR state after one Galois step
module sdram_pattern_gen
  import sdram_test_gen_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 24
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] lfsr_i,
  output logic [DATA_W-1:0] exp_o,
  output logic [DATA_W-1:0] lfsr_next_o
);

  localparam logic [31:0] TAPS_FULL = lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] TAPS = TAPS_FULL[DATA_W-1:0];
  // Wide enough for both the address and the DATA_W divisor.
  localparam int IDX_W = (ADDR_W > 32) ? ADDR_W : 32;

  logic [IDX_W-1:0]  addr_wide;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] addr_word;

  always_comb begin
    addr_wide   = IDX_W'(addr_i);
    bit_idx     = addr_wide % IDX_W'(DATA_W);
    addr_word   = DATA_W'(addr_i);
    lfsr_next_o = (lfsr_i >> 1) ^ (lfsr_i[0] ? TAPS : '0);
    exp_o       = addr_word;
    case (mode_i)
      MODE_ADDR: exp_o = addr_word;
      MODE_LFSR: exp_o = lfsr_i;
      MODE_WALK: exp_o = DATA_W'(1) << bit_idx;
      MODE_INV:  exp_o = ~addr_word;
      default:   exp_o = addr_word;
    endcase
  end

endmodule

// File: rtl/sdram_test_gen.sv
// sdram_test_gen: memory tester that writes a pattern over addresses
// 0..ADDR_LAST through an SDRAM controller host port, reads it all back,
// counts mismatches, and repeats for the requested number of passes.
//
// Host handshake: a request (host_wr_o or host_rd_o) is held with stable
// address/data until the controller returns a one-cycle host_done_i; the
// strobe is low in the cycle after done (a one-cycle gap between
// back-to-back writes), and done seen while no request is up is ignored.
//
// Ports:
//   master_clk_i, rst_i (sync, active-high), start_i (one-cycle pulse)
//   mode_i, passes_i        : test configuration, latched on start
//   host_wr_o/rd_o/addr_o/data_o, host_data_i/done_i : controller host port
//   busy_o, pass_o, fail_o  : status
//   err_cnt_o, fail_addr_o, pass_cnt_o : results
//   dbg_state_o             : current FSM state (state_e encoding)
module sdram_test_gen
  import sdram_test_gen_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 24,
  // All-ones equals 2**ADDR_W-1: test the full address space.
  parameter logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}},
  parameter int                ERR_W     = 8,
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(1)
) (
  input  logic              master_clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [3:0]        passes_i,
  output logic              host_wr_o,
  output logic              host_rd_o,
  output logic [ADDR_W-1:0] host_addr_o,
  output logic [DATA_W-1:0] host_data_o,
  input  logic [DATA_W-1:0] host_data_i,
  input  logic              host_done_i,
  output logic              busy_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [3:0]        pass_cnt_o,
  output logic [2:0]        dbg_state_o
);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        passes_q, passes_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  // LFSR state at the start of the current pass; reads replay from here.
  logic [DATA_W-1:0] lfsr_start_q, lfsr_start_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [3:0]        pass_cnt_q, pass_cnt_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  // Forces the write strobe low for the cycle after each write done.
  logic              gap_q, gap_d;

  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] lfsr_next;
  logic [3:0]        pass_cnt_inc;

  sdram_pattern_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_pattern_gen (
    .addr_i      (addr_q),
    .mode_i      (mode_q),
    .lfsr_i      (lfsr_q),
    .exp_o       (exp_word),
    .lfsr_next_o (lfsr_next)
  );

  always_ff @(posedge master_clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      mode_q       <= '0;
      passes_q     <= '0;
      addr_q       <= '0;
      lfsr_q       <= LFSR_SEED;
      lfsr_start_q <= LFSR_SEED;
      rd_data_q    <= '0;
      err_cnt_q    <= '0;
      fail_addr_q  <= '0;
      pass_cnt_q   <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      gap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      passes_q     <= passes_d;
      addr_q       <= addr_d;
      lfsr_q       <= lfsr_d;
      lfsr_start_q <= lfsr_start_d;
      rd_data_q    <= rd_data_d;
      err_cnt_q    <= err_cnt_d;
      fail_addr_q  <= fail_addr_d;
      pass_cnt_q   <= pass_cnt_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      gap_q        <= gap_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    passes_d     = passes_q;
    addr_d       = addr_q;
    lfsr_d       = lfsr_q;
    lfsr_start_d = lfsr_start_q;
    rd_data_d    = rd_data_q;
    err_cnt_d    = err_cnt_q;
    fail_addr_d  = fail_addr_q;
    pass_cnt_d   = pass_cnt_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    gap_d        = 1'b0;
    // A 4-bit count wraps to 0 after 16 passes, matching passes_i=0.
    pass_cnt_inc = pass_cnt_q + 4'd1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          mode_d       = mode_i;
          passes_d     = passes_i;
          err_cnt_d    = '0;
          fail_addr_d  = '0;
          pass_cnt_d   = '0;
          pass_d       = 1'b0;
          fail_d       = 1'b0;
          addr_d       = '0;
          lfsr_d       = LFSR_SEED;
          lfsr_start_d = LFSR_SEED;
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (host_done_i && !gap_q) begin
          if (addr_q == ADDR_LAST) begin
            addr_d  = '0;
            lfsr_d  = lfsr_start_q;
            state_d = ST_READ;
          end else begin
            addr_d = addr_q + 1'b1;
            lfsr_d = lfsr_next;
            gap_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (host_done_i) begin
          rd_data_d = host_data_i;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rd_data_q != exp_word) begin
          if (err_cnt_q == '0) begin
            fail_addr_d = addr_q;
          end
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        lfsr_d = lfsr_next;
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          state_d = ST_PASS_END;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_READ;
        end
      end
      ST_PASS_END: begin
        pass_cnt_d = pass_cnt_inc;
        if (pass_cnt_inc == passes_q) begin
          pass_d  = (err_cnt_q == '0);
          fail_d  = (err_cnt_q != '0);
          state_d = ST_DONE;
        end else begin
          // Next pass continues the LFSR sequence, so it writes new data.
          addr_d       = '0;
          lfsr_start_d = lfsr_q;
          state_d      = ST_WRITE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign host_wr_o   = (state_q == ST_WRITE) && !gap_q;
  assign host_rd_o   = (state_q == ST_READ);
  assign host_addr_o = addr_q;
  assign host_data_o = host_wr_o ? exp_word : '0;
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign err_cnt_o   = err_cnt_q;
  assign fail_addr_o = fail_addr_q;
  assign pass_cnt_o  = pass_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sdram_test_gen.sv
module tb_sdram_test_gen;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = '0;
  logic [3:0]  passes_i = '0;
  logic        host_wr_o, host_rd_o;
  logic [7:0]  host_addr_o;
  logic [15:0] host_data_o;
  logic [15:0] host_data_i = '0;
  logic        host_done_i = 1'b0;
  logic        busy_o, pass_o, fail_o;
  logic [1:0]  err_cnt_o;
  logic [7:0]  fail_addr_o;
  logic [3:0]  pass_cnt_o;
  logic [2:0]  dbg_state_o;

  always #5 clk = ~clk;

  sdram_test_gen #(
    .DATA_W    (16),
    .ADDR_W    (8),
    .ADDR_LAST (8'd15),
    .ERR_W     (2),
    .LFSR_SEED (16'h0001)
  ) dut (
    .master_clk_i (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .passes_i     (passes_i),
    .host_wr_o    (host_wr_o),
    .host_rd_o    (host_rd_o),
    .host_addr_o  (host_addr_o),
    .host_data_o  (host_data_o),
    .host_data_i  (host_data_i),
    .host_done_i  (host_done_i),
    .busy_o       (busy_o),
    .pass_o       (pass_o),
    .fail_o       (fail_o),
    .err_cnt_o    (err_cnt_o),
    .fail_addr_o  (fail_addr_o),
    .pass_cnt_o   (pass_cnt_o),
    .dbg_state_o  (dbg_state_o)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [23:0] exp_q[$];     // expected writes {addr, data} in order
  logic [15:0] mem [0:255];
  logic [15:0] corrupt [0:15];
  bit          zero_mem = 0;
  int          lat_min = 0, lat_max = 0;
  int          cfg_passes = 1;
  int          exp_err = 0, exp_fail_addr = 0;
  int          rd_cnt = 0;

  // Maximal-length 16-bit polynomial x^16+x^15+x^13+x^4+1, Galois form.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hD008) : (s >> 1);
  endfunction

  function automatic logic [15:0] pattern(input int mode, input int a,
                                          input logic [15:0] l);
    logic [15:0] av;
    av = 16'(a);
    case (mode)
      0: return av;
      1: return l;
      2: return 16'(1) << (a % 16);
      default: return ~av;
    endcase
  endfunction

  // Memory/controller model: done after a random number of request cycles.
  int          ws = 0, lat = 0;
  bit          last_wr = 0;
  logic [7:0]  cur_addr;
  logic [15:0] cur_data;
  logic [23:0] exp_w;

  always @(negedge clk) begin
    if (host_done_i) begin
      host_done_i = 1'b0;
      ws = 0;
      checks++;
      if ((last_wr ? host_wr_o : host_rd_o) !== 1'b0) begin
        failures++;
        $display("FAIL strobe_drop: wr=%0b rd=%0b after done, required 0", host_wr_o, host_rd_o);
      end
    end else if (host_wr_o || host_rd_o) begin
      if (ws == 0) begin
        cur_addr = host_addr_o;
        cur_data = host_data_o;
        lat = $urandom_range(lat_max, lat_min);
      end else begin
        checks++;
        if (host_addr_o !== cur_addr || (host_wr_o && host_data_o !== cur_data)) begin
          failures++;
          $display("FAIL req_stable: addr=%0h data=%0h, required addr=%0h data=%0h",
                   host_addr_o, host_data_o, cur_addr, cur_data);
        end
      end
      if (ws == lat) begin
        host_done_i = 1'b1;
        last_wr = host_wr_o;
        if (host_wr_o) begin
          mem[cur_addr] = cur_data;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL write_seq: unexpected write addr=%0h data=%0h, required none", cur_addr, cur_data);
          end else begin
            exp_w = exp_q.pop_front();
            if ({cur_addr, cur_data} !== exp_w) begin
              failures++;
              $display("FAIL write_seq: got addr=%0h data=%0h, required addr=%0h data=%0h",
                       cur_addr, cur_data, exp_w[23:16], exp_w[15:0]);
            end
          end
        end else begin
          host_data_i = zero_mem ? 16'h0 : (mem[cur_addr] ^ corrupt[cur_addr[3:0]]);
          rd_cnt++;
        end
      end
      ws++;
    end else begin
      ws = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_faults();
    for (int i = 0; i < 16; i++) corrupt[i] = '0;
    zero_mem = 0;
  endtask

  task automatic start_run(input int mode, input int passes);
    logic [15:0] l, w, rd;
    bit found;
    exp_q.delete();
    cfg_passes = passes;
    l = 16'h0001;
    exp_err = 0;
    exp_fail_addr = 0;
    found = 0;
    for (int p = 0; p < passes; p++) begin
      for (int a = 0; a < 16; a++) begin
        w = pattern(mode, a, l);
        exp_q.push_back({8'(a), w});
        l = lfsr_step(l);
        rd = zero_mem ? 16'h0 : (w ^ corrupt[a]);
        if (rd != w) begin
          if (!found) begin
            exp_fail_addr = a;
            found = 1;
          end
          if (exp_err < 3) exp_err++;
        end
      end
    end
    rd_cnt = 0;
    @(negedge clk);
    mode_i = 2'(mode);
    passes_i = (passes == 16) ? 4'd0 : 4'(passes);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic finish_run(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 30000 && !done; c++) begin
      @(negedge clk);
      if (!busy_o) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: busy_o still 1, required 0", name);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      return;
    end
    checks++;
    if ({pass_o, fail_o} !== {exp_err == 0, exp_err != 0}) begin
      failures++;
      $display("FAIL %s_status: pass=%0b fail=%0b, required pass=%0b fail=%0b",
               name, pass_o, fail_o, exp_err == 0, exp_err != 0);
    end
    checks++;
    if (err_cnt_o !== 2'(exp_err)) begin
      failures++;
      $display("FAIL %s_err_cnt: got %0d, required %0d", name, err_cnt_o, exp_err);
    end
    checks++;
    if (fail_addr_o !== 8'(exp_fail_addr)) begin
      failures++;
      $display("FAIL %s_fail_addr: got %0h, required %0h", name, fail_addr_o, exp_fail_addr);
    end
    checks++;
    if (pass_cnt_o !== 4'(cfg_passes)) begin
      failures++;
      $display("FAIL %s_pass_cnt: got %0d, required %0d", name, pass_cnt_o, 4'(cfg_passes));
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_writes: %0d writes missing, required 0", name, exp_q.size());
    end
    checks++;
    if (rd_cnt != cfg_passes * 16) begin
      failures++;
      $display("FAIL %s_reads: got %0d reads, required %0d", name, rd_cnt, cfg_passes * 16);
    end
    checks++;
    if ({host_wr_o, host_rd_o} !== 2'b00) begin
      failures++;
      $display("FAIL %s_idle_strobes: wr=%0b rd=%0b, required 0", name, host_wr_o, host_rd_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    start_i = 1'b1;   // reset must win over start
    repeat (3) @(negedge clk);
    checks++;
    if ({host_wr_o, host_rd_o, host_addr_o, host_data_o, busy_o, pass_o, fail_o,
         err_cnt_o, fail_addr_o, pass_cnt_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: wr=%0b rd=%0b addr=%0h data=%0h busy=%0b pass=%0b fail=%0b err=%0d fa=%0h pc=%0d, required all 0",
               host_wr_o, host_rd_o, host_addr_o, host_data_o, busy_o, pass_o, fail_o,
               err_cnt_o, fail_addr_o, pass_cnt_o);
    end
    start_i = 1'b0;
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy: got %0b, required 0", busy_o);
    end
  endtask

  task automatic test_addr_clean();
    clear_faults();
    lat_min = 0; lat_max = 0;
    start_run(0, 1);
    finish_run("addr_clean");
  endtask

  task automatic test_corrupt();
    clear_faults();
    corrupt[5] = 16'h0001;
    corrupt[9] = 16'h8000;
    lat_min = 0; lat_max = 0;
    start_run(0, 1);
    finish_run("corrupt");
  endtask

  task automatic test_lfsr_two_pass();
    clear_faults();
    lat_min = 0; lat_max = 1;
    start_run(1, 2);
    finish_run("lfsr_two_pass");
  endtask

  task automatic test_random_latency();
    clear_faults();
    lat_min = 3; lat_max = 7;
    start_run(int'($urandom_range(3, 0)), 1);
    finish_run("slow_mem");
  endtask

  task automatic test_walking_one();
    clear_faults();
    corrupt[int'($urandom_range(15, 0))] = 16'h0100;
    lat_min = 0; lat_max = 2;
    start_run(2, 2);
    finish_run("walking_one");
  endtask

  task automatic test_saturate();
    clear_faults();
    zero_mem = 1;
    lat_min = 0; lat_max = 0;
    start_run(3, 1);
    finish_run("saturate");
    zero_mem = 0;
  endtask

  task automatic test_sixteen_passes();
    clear_faults();
    lat_min = 0; lat_max = 0;
    start_run(0, 16);
    finish_run("sixteen_passes");
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    clear_faults();
    lat_min = 2; lat_max = 2;
    start_run(1, 1);
    seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (host_rd_o) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL mid_read_wait: host_rd_o never 1, required 1");
    end
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({host_wr_o, host_rd_o, host_addr_o, host_data_o, busy_o, pass_o, fail_o,
         err_cnt_o, fail_addr_o, pass_cnt_o} !== '0) begin
      failures++;
      $display("FAIL mid_read_reset: wr=%0b rd=%0b addr=%0h busy=%0b err=%0d pc=%0d, required all 0",
               host_wr_o, host_rd_o, host_addr_o, busy_o, err_cnt_o, pass_cnt_o);
    end
    rst_i = 1'b0;
    exp_q.delete();
    lat_min = 0; lat_max = 1;
    start_run(0, 1);
    finish_run("after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      clear_faults();
      for (int a = 0; a < 16; a++)
        if ($urandom_range(3, 0) == 0) corrupt[a] = 16'($urandom_range(16'hFFFF, 1));
      lat_min = 0; lat_max = int'($urandom_range(3, 0));
      start_run(int'($urandom_range(3, 0)), int'($urandom_range(3, 1)));
      // A start while busy must not disturb the running test.
      repeat (10) @(negedge clk);
      mode_i = ~mode_i;
      passes_i = 4'd7;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      finish_run("random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    clear_faults();
    test_reset();
    test_addr_clean();
    test_corrupt();
    test_lfsr_two_pass();
    test_random_latency();
    test_walking_one();
    test_saturate();
    test_sixteen_passes();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
